uart_recv: RTL and testbench
============================

Name: uart_recv

Overview:
- UART receive path for 8N1 frames: idle-high line, one start bit (low), DATA_BITS data bits LSB first, one stop bit (high).
- Counterpart to the transmit path; shares its serial line format and bit timing.
- Oversamples the serial input with the system clock, recovers bytes, and holds each byte in a one-deep output register with a ready/acknowledge handshake.
- Reports framing errors and overruns to the consumer logic.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 4
DATA_BITS, 8, data bits per frame; RxData width

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
RxIn  input  1  asynchronous serial line, idle high
RxAck  input  1  consumer acknowledge; one-cycle pulse releases RxData
RxData  output  DATA_BITS  last correctly received byte
RxFull  output  1  RxData holds an unacknowledged byte
FrameErr  output  1  sticky: a frame ended with a low stop bit
Overrun  output  1  sticky: a byte arrived while RxFull was 1
RxBusy  output  1  a frame is being received (state != IDLE)

Behaviour:
- Input conditioning:
  - RxIn passes through a 2-flop synchronizer. Both flops reset to 1.
  - A registered copy of the synchronized line, prevLine, also resets to 1.
- Reset values: RxData=0, RxFull=0, FrameErr=0, Overrun=0, RxBusy=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame. No partial data is ever loaded.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of the synchronized line (prevLine=1, line=0), go to START and clear the bit-timer.
    - A line that is held low, such as a break or the tail of a bad frame, never starts a frame. A new frame starts only after the line returns high.
  - START: when the bit-timer reaches CLKS_PER_BIT/2-1, sample the line.
    - Low: valid start; go to DATA, clear the bit-timer and bit index.
    - High: glitch; return to IDLE with no output change.
  - DATA: every CLKS_PER_BIT cycles (timer wraps at CLKS_PER_BIT-1), sample the line into shift register bit [index], LSB first. After the DATA_BITS-th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the line and return to IDLE on the same edge.
    - High (good frame): load the shift register into RxData and set RxFull=1.
    - Low (framing error): set FrameErr=1. RxData and RxFull are unchanged and the byte is discarded.
- Samples therefore land mid-bit. The stop sample falls (9.5*CLKS_PER_BIT + 2) +/- 1 cycles after RxIn first goes low, allowing for synchronizer phase.
- RxFull, RxData, FrameErr and Overrun update on the edge following the stop sample.
- Handshake:
  - RxAck while RxFull=1 clears RxFull, FrameErr and Overrun on the next edge.
  - RxAck while RxFull=0 clears only FrameErr and Overrun.
- Overrun: a good frame completing while RxFull=1 with no RxAck on the same edge overwrites RxData, keeps RxFull=1 and sets Overrun=1.
- Simultaneous RxAck and good-frame completion: the new byte is loaded, RxFull stays 1 and Overrun is not set. The ack applies to the old byte.
- Simultaneous RxAck and framing error: FrameErr=1 (set wins over clear) and RxFull is cleared.
- Back-to-back frames: a falling edge seen in the IDLE cycle immediately after STOP starts the next frame. No extra idle time is required beyond the stop bit.
- Timing and widths:
  - Bit-timer width is $clog2(CLKS_PER_BIT).
  - Bit index width is $clog2(DATA_BITS+1).
  - Counters never wrap outside their state's range.
- RxBusy = (state != IDLE), registered with the state.

Test Plan:
- Reset, then drive the 8N1 frame for 0xA5 at CLKS_PER_BIT=16 -> RxFull rises 153-157 cycles after the start edge; RxData=0xA5, FrameErr=0, Overrun=0, RxBusy falls on the same edge. Pulse RxAck -> RxFull=0 next cycle and RxData holds 0xA5.
- Low glitch of 4 cycles on idle RxIn -> RxBusy pulses for at most 10 cycles; RxFull, RxData and FrameErr unchanged.
- Frame 0x3C with the stop bit held low for 2 bits, then line high -> FrameErr=1, RxFull=0, RxData keeps its previous value, no frame starts while the line is low. Next good frame 0x81 -> RxData=0x81, RxFull=1, FrameErr stays 1 until RxAck.
- Two back-to-back good frames 0x11 then 0x22 with no RxAck -> after the second frame RxData=0x22, RxFull=1, Overrun=1. RxAck -> all three flags 0.
- Frame 0x55 completes while RxFull=1 (holding 0x66), with RxAck asserted exactly on the completion edge -> RxData=0x55, RxFull=1, Overrun=0.
- Assert reset for 1 cycle during data bit 4 of frame 0xF0 -> all outputs 0, state IDLE. The remaining bits of that frame produce no RxFull. A following clean frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop synchronized, mid-bit sampled, one-deep output register with RxAck release.
// Byte visible on the stop-sample edge (~9.5 bits after start); no backpressure, unacknowledged bytes are overwritten and flagged.
module uart_recv #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 RxIn,
    input  logic                 RxAck,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxFull,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 RxBusy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic                 sync1;
    logic                 line;
    logic                 prev_line;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;

    // Synchronizer and edge-detect history idle high so reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            prev_line <= 1'b1;
        end else begin
            sync1     <= RxIn;
            line      <= sync1;
            prev_line <= line;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            idx      <= '0;
            shreg    <= '0;
            RxData   <= '0;
            RxFull   <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
            RxBusy   <= 1'b0;
        end else begin
            // Ack clears first; frame completion below overrides on the same edge.
            if (RxAck) begin
                RxFull   <= 1'b0;
                FrameErr <= 1'b0;
                Overrun  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (prev_line && !line) begin
                        state  <= START;
                        timer  <= '0;
                        RxBusy <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        if (!line) begin
                            state <= DATA;
                            timer <= '0;
                            idx   <= '0;
                        end else begin
                            state  <= IDLE;
                            timer  <= '0;
                            RxBusy <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        // LSB arrives first, so shifting right lands each bit at its index.
                        shreg <= {line, shreg[DATA_BITS-1:1]};
                        timer <= '0;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        state  <= IDLE;
                        timer  <= '0;
                        RxBusy <= 1'b0;
                        if (line) begin
                            RxData <= shreg;
                            RxFull <= 1'b1;
                            if (RxFull && !RxAck) begin
                                Overrun <= 1'b1;
                            end
                        end else begin
                            FrameErr <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    RxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Randomized and directed bench for uart_recv against a frame-level model of the output register and flags.
module tb_uart_recv;

    localparam int CPB = 16;
    localparam int DB  = 8;
    // Line changes just after an edge, so the stop sample lands at the late end of 9.5*CPB+2 +/- 1.
    localparam int STOP_EDGE = (19 * CPB) / 2 + 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          RxIn  = 1'b1;
    logic          RxAck = 1'b0;
    logic [DB-1:0] RxData;
    logic          RxFull;
    logic          FrameErr;
    logic          Overrun;
    logic          RxBusy;

    int checks = 0;
    int errors = 0;

    logic [DB-1:0] m_data;
    logic          m_full;
    logic          m_ferr;
    logic          m_ovr;

    int rise_at;
    int fall_at;
    int rebusy;

    uart_recv #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .RxIn     (RxIn),
        .RxAck    (RxAck),
        .RxData   (RxData),
        .RxFull   (RxFull),
        .FrameErr (FrameErr),
        .Overrun  (Overrun),
        .RxBusy   (RxBusy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/data"}, 32'(RxData), 32'(m_data));
        check({tag, "/full"}, 32'(RxFull), 32'(m_full));
        check({tag, "/ferr"}, 32'(FrameErr), 32'(m_ferr));
        check({tag, "/ovr"}, 32'(Overrun), 32'(m_ovr));
        check({tag, "/busy"}, 32'(RxBusy), 32'(0));
    endtask

    task automatic model_reset();
        m_data = '0;
        m_full = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Frame completion: the ack releases the old byte, then the new result is applied.
    task automatic model_done(input logic good, input logic [DB-1:0] b, input logic ack);
        logic was_full;
        was_full = m_full;
        if (ack) begin
            m_full = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (good) begin
            m_data = b;
            m_full = 1'b1;
            if (was_full && !ack) m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        RxAck = 1'b1;
        tick();
        RxAck = 1'b0;
        m_full = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic idle(input int n);
        RxIn = 1'b1;
        repeat (n) tick();
    endtask

    // Drives one frame; ack_edge / rst_edge pick the edge (counted from the start bit) for RxAck / reset.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop_val, input int stop_ticks,
                              input int ack_edge, input int rst_edge);
        int   cnt;
        int   n;
        logic pf;
        logic pb;
        cnt     = 0;
        rise_at = -1;
        fall_at = -1;
        rebusy  = 0;
        for (int p = 0; p < DB + 2; p++) begin
            n = (p == DB + 1) ? stop_ticks : CPB;
            if (p == 0)           RxIn = 1'b0;
            else if (p == DB + 1) RxIn = stop_val;
            else                  RxIn = b[p-1];
            for (int k = 0; k < n; k++) begin
                RxAck = (cnt + 1 == ack_edge);
                reset = (cnt + 1 == rst_edge);
                pf = RxFull;
                pb = RxBusy;
                tick();
                cnt++;
                if (reset) begin
                    reset = 1'b0;
                    model_reset();
                    check_all("midrst");
                end
                if (!pf && RxFull && rise_at < 0) rise_at = cnt;
                if (pb && !RxBusy && fall_at < 0) fall_at = cnt;
                else if (fall_at >= 0 && RxBusy)  rebusy = 1;
            end
        end
        RxAck = 1'b0;
        RxIn  = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [DB-1:0] b;
        logic good;
        int ack_e;

        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all("reset");

        // Basic frame with latency window.
        idle(4);
        send_frame(8'hA5, 1'b1, CPB, -1, -1);
        check("t1/rise_win", 32'(rise_at >= 153 && rise_at <= 157), 32'(1));
        check("t1/busy_fall", 32'(fall_at), 32'(rise_at));
        model_done(1'b1, 8'hA5, 1'b0);
        check_all("t1");
        pulse_ack();
        check_all("t1ack");

        // Short low glitch on idle line.
        RxIn = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) RxIn = 1'b1;
            tick();
            if (RxBusy) busy_cnt++;
        end
        check("t2/busy_pulse", 32'(busy_cnt >= 1 && busy_cnt <= 10), 32'(1));
        check_all("t2");

        // Stop bit held low for two bits.
        send_frame(8'h3C, 1'b0, 2 * CPB, -1, -1);
        model_done(1'b0, 8'h3C, 1'b0);
        check_all("t3");
        check("t3/no_restart", 32'(rebusy), 32'(0));
        check("t3/fall", 32'(fall_at), 32'(STOP_EDGE));
        idle(4);
        send_frame(8'h81, 1'b1, CPB, -1, -1);
        model_done(1'b1, 8'h81, 1'b0);
        check_all("t3b");
        pulse_ack();
        check_all("t3ack");

        // Back-to-back frames with no ack: overrun.
        idle(4);
        send_frame(8'h11, 1'b1, CPB, -1, -1);
        model_done(1'b1, 8'h11, 1'b0);
        check_all("t4a");
        send_frame(8'h22, 1'b1, CPB, -1, -1);
        model_done(1'b1, 8'h22, 1'b0);
        check_all("t4b");
        pulse_ack();
        check_all("t4ack");

        // Ack exactly on the completion edge.
        idle(4);
        send_frame(8'h66, 1'b1, CPB, -1, -1);
        model_done(1'b1, 8'h66, 1'b0);
        check_all("t5a");
        idle(4);
        send_frame(8'h55, 1'b1, CPB, STOP_EDGE, -1);
        model_done(1'b1, 8'h55, 1'b1);
        check_all("t5b");

        // Reset during data bit 4.
        idle(4);
        send_frame(8'hF0, 1'b1, CPB, -1, CPB + 4 * CPB + CPB / 2);
        check_all("t6");
        idle(4);
        send_frame(8'h0F, 1'b1, CPB, -1, -1);
        model_done(1'b1, 8'h0F, 1'b0);
        check_all("t6b");
        pulse_ack();

        // Randomized frames, stop errors, acks and gaps.
        idle(4);
        for (int it = 0; it < 20; it++) begin
            b     = DB'($urandom);
            good  = ($urandom_range(0, 4) != 0);
            ack_e = ($urandom_range(0, 3) == 0) ? STOP_EDGE : -1;
            send_frame(b, good, good ? CPB : 2 * CPB, ack_e, -1);
            model_done(good, b, ack_e >= 0);
            check_all("rnd");
            check("rnd/fall", 32'(fall_at), 32'(STOP_EDGE));
            if ($urandom_range(0, 2) == 0) begin
                pulse_ack();
                check_all("rndack");
            end
            idle(good ? $urandom_range(0, 3) : $urandom_range(3, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
